// File: rtl/replay_sampler_if.sv
// Index stream from the replay sampler to the replay memory read port.
// The sampler drives the master side; the memory read port is the slave.
interface replay_sampler_if #(
    parameter int ADDR_W = 10
);
    logic              idx_valid;
    logic              idx_ready;
    logic [ADDR_W-1:0] idx;
    logic              idx_last;

    modport master (
        output idx_valid,
        output idx,
        output idx_last,
        input  idx_ready
    );

    modport slave (
        input  idx_valid,
        input  idx,
        input  idx_last,
        output idx_ready
    );
endinterface

// File: rtl/replay_sampler.sv
// Draws uniform slot indices in [0, fill_count) from a free-running LFSR.
// Also loads the LFSR seed after reset and on request.
module replay_sampler #(
    parameter int               NBITS     = 16,
    parameter int               ADDR_W    = 10,
    parameter int               BATCH_W   = 8,
    parameter logic [NBITS-1:0] SEED      = 16'hACE1,
    parameter int               STALL_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NBITS-1:0]   lfsr_q,
    output logic               lfsr_we,
    output logic [NBITS-1:0]   lfsr_data,
    input  logic               seed_load,
    input  logic [NBITS-1:0]   seed_in,
    input  logic               start,
    input  logic [ADDR_W:0]    fill_count,
    input  logic [BATCH_W-1:0] batch_size,
    replay_sampler_if.master   idx_bus,
    output logic               busy,
    output logic               done,
    output logic               err_empty,
    output logic               err_stall
);
    localparam int REJ_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        SEED_AUTO,
        IDLE,
        DRAW,
        HOLD
    } state_t;

    // Smallest all-ones mask covering v, so masked draws stay near-uniform.
    function automatic logic [ADDR_W-1:0] smear(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] m;
        m = v;
        for (int i = 0; i < ADDR_W; i++) begin
            m = m | (m >> 1);
        end
        return m;
    endfunction

    state_t             state, nxt;
    logic [ADDR_W:0]    fc, fc_d;
    logic [BATCH_W-1:0] rem, rem_d;
    logic [ADDR_W-1:0]  mask, mask_d;
    logic [REJ_W-1:0]   rej, rej_d, rej_inc;
    logic [ADDR_W-1:0]  cand;
    logic               accept, stall_hit, go;
    logic               lfsr_unused;

    logic               we_d, valid_d, last_d;
    logic [NBITS-1:0]   data_d;
    logic [ADDR_W-1:0]  idx_d;
    logic               busy_d, done_d, empty_d, stall_d;

    assign lfsr_unused = ^lfsr_q;
    assign cand        = lfsr_q[ADDR_W-1:0] & mask;
    assign accept      = ({1'b0, cand} < fc);
    assign rej_inc     = rej + 1'b1;
    assign stall_hit   = (rej_inc == REJ_W'(STALL_MAX));
    assign go          = start && !seed_load
                         && (fill_count != '0) && (batch_size != '0);

    // State register; reset always returns to auto-seeding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEED_AUTO;
        else      state <= nxt;
    end

    // Next-state decision.
    always_comb begin
        nxt = state;
        unique case (state)
            SEED_AUTO: nxt = IDLE;
            IDLE:      if (go) nxt = DRAW;
            DRAW: begin
                if (accept)         nxt = HOLD;
                else if (stall_hit) nxt = IDLE;
            end
            HOLD: begin
                if (idx_bus.idx_ready)
                    nxt = (rem == BATCH_W'(1)) ? IDLE : DRAW;
            end
            default:   nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and batch bookkeeping.
    always_comb begin
        we_d    = 1'b0;
        data_d  = lfsr_data;
        valid_d = 1'b0;
        last_d  = idx_bus.idx_last;
        idx_d   = idx_bus.idx;
        done_d  = 1'b0;
        empty_d = 1'b0;
        stall_d = 1'b0;
        busy_d  = (nxt != IDLE);
        fc_d    = fc;
        rem_d   = rem;
        mask_d  = mask;
        rej_d   = rej;
        unique case (state)
            SEED_AUTO: begin
                we_d   = 1'b1;
                data_d = SEED;
            end
            IDLE: begin
                if (seed_load) begin
                    we_d   = 1'b1;
                    data_d = (seed_in == '0) ? SEED : seed_in;
                end else if (start) begin
                    if (fill_count == '0) begin
                        empty_d = 1'b1;
                    end else if (batch_size == '0) begin
                        done_d = 1'b1;
                    end else begin
                        fc_d   = fill_count;
                        rem_d  = batch_size;
                        mask_d = smear(ADDR_W'(fill_count - 1'b1));
                        rej_d  = '0;
                    end
                end
            end
            DRAW: begin
                if (accept) begin
                    idx_d   = cand;
                    valid_d = 1'b1;
                    last_d  = (rem == BATCH_W'(1));
                    rej_d   = '0;
                end else if (stall_hit) begin
                    stall_d = 1'b1;
                    rej_d   = '0;
                end else begin
                    rej_d = rej_inc;
                end
            end
            HOLD: begin
                valid_d = 1'b1;
                if (idx_bus.idx_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    rem_d   = rem - 1'b1;
                    done_d  = (rem == BATCH_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_we           <= 1'b0;
            lfsr_data         <= '0;
            idx_bus.idx_valid <= 1'b0;
            idx_bus.idx       <= '0;
            idx_bus.idx_last  <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err_empty         <= 1'b0;
            err_stall         <= 1'b0;
            fc                <= '0;
            rem               <= '0;
            mask              <= '0;
            rej               <= '0;
        end else begin
            lfsr_we           <= we_d;
            lfsr_data         <= data_d;
            idx_bus.idx_valid <= valid_d;
            idx_bus.idx       <= idx_d;
            idx_bus.idx_last  <= last_d;
            busy              <= busy_d;
            done              <= done_d;
            err_empty         <= empty_d;
            err_stall         <= stall_d;
            fc                <= fc_d;
            rem               <= rem_d;
            mask              <= mask_d;
            rej               <= rej_d;
        end
    end
endmodule

// File: doc/replay_sampler.md
Name: replay_sampler

Overview:
- Downstream consumer of the 16-bit LFSR. Turns its pseudo-random stream into a batch of uniformly distributed replay-buffer slot indices in [0, fill_count).
- Indices are issued over a valid/ready stream to the replay memory read port.
- Owns LFSR seeding: after reset, the LFSR sits in its all-zero lock-up state until loaded, so this block loads the seed.

Parameters:
- NBITS, 16, LFSR width.
- ADDR_W, 10, index width; buffer depth is 2^ADDR_W. ADDR_W <= NBITS.
- BATCH_W, 8, width of batch_size.
- SEED, 16'hACE1, default nonzero seed.
- STALL_MAX, 255, consecutive rejections tolerated before abort.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- lfsr_q  in  NBITS  current LFSR state
- lfsr_we  out  1  LFSR load strobe
- lfsr_data  out  NBITS  LFSR load value
- seed_load  in  1  request reseed; honoured only in IDLE
- seed_in  in  NBITS  reseed value
- start  in  1  begin batch; honoured only in IDLE
- fill_count  in  ADDR_W+1  valid entries in buffer, 0..2^ADDR_W; latched at start
- batch_size  in  BATCH_W  indices to produce; latched at start
- idx_valid  out  1  index available
- idx_ready  in  1  consumer accepts
- idx  out  ADDR_W  sampled index
- idx_last  out  1  qualifies final index of batch
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at batch end
- err_empty  out  1  one-cycle pulse: start with fill_count==0
- err_stall  out  1  one-cycle pulse: rejection limit hit

Behaviour:
- Reset values: all outputs 0; state SEED_AUTO; remaining count, mask, reject counter all 0.
- All outputs are registered.
- SEED_AUTO: lfsr_we=1 and lfsr_data=SEED for exactly one cycle, then go to IDLE. This state is entered only from reset, including reset asserted mid-batch.
- IDLE:
  - seed_load=1: lfsr_we=1 for one cycle with lfsr_data=seed_in. If seed_in==0, lfsr_data=SEED instead (avoids lock-up).
  - start=1 with seed_load=1 in the same cycle: seed wins; start is dropped.
  - start with fill_count==0: err_empty pulse; stay in IDLE.
  - start with batch_size==0: done pulse; stay in IDLE.
  - Otherwise: latch fill_count as fc and batch_size as rem; compute mask = (fc-1) with all lower bits set by OR-smear (fc=1 gives mask 0; fc=2^ADDR_W gives all ones). Go to DRAW.
- DRAW:
  - cand = lfsr_q[ADDR_W-1:0] & mask.
  - cand < fc: register idx=cand; idx_valid=1; idx_last=(rem==1); clear reject counter; go to HOLD.
  - Otherwise: reject and increment reject counter. When the counter reaches STALL_MAX: err_stall pulse, idx_valid stays 0, go to IDLE (batch aborted, no done).
- HOLD:
  - idx, idx_valid and idx_last stay stable until idx_ready=1.
  - On handshake, rem decrements. If rem was 1: idx_valid=0, done pulse, go to IDLE. Otherwise return to DRAW with idx_valid=0. There is no back-to-back issue, so at most one index every 2 cycles.
- Latency: start sampled in cycle N gives DRAW in N+1; earliest idx_valid in N+2.
- LFSR runs freely every clock. The sampler never stalls it; consecutive draws come from different LFSR states.
- start and seed_load outside IDLE are ignored; no queuing.
- fill_count changes after start have no effect on the current batch.
- Repeated indices within a batch are permitted (sampling with replacement).

Test Plan:
- Release reset -> lfsr_we high exactly 1 cycle, lfsr_data=16'hACE1; busy low afterwards.
- IDLE, seed_load=1, seed_in=0 -> lfsr_we 1 cycle, lfsr_data=16'hACE1. Then seed_in=16'h1234 -> lfsr_data=16'h1234.
- start, fill_count=0 -> err_empty 1 cycle, no idx_valid, busy low.
- fill_count=1, batch_size=4, idx_ready=1 -> four handshakes all idx=0; idx_last only on the 4th; done one cycle after the 4th handshake.
- fill_count=5, lfsr_q forced to 16'h03FF -> mask=7, cand=7 always rejected -> err_stall after 255 DRAW cycles, no idx_valid.
- fill_count=1024, batch_size=2, idx_ready low 5 cycles -> idx equals lfsr_q[9:0] from the DRAW cycle and is held stable; reset asserted mid-HOLD -> idx_valid=0 immediately, then auto-seed.
